// File: rtl/frame_builder_if.sv
// Bus bundles for frame_builder: the command FIFO read side and the
// 64-bit AXI-Stream transmit side. "master" drives data/valid, "slave"
// drives ready.

interface frame_builder_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_size;
  logic [47:0] cmd_d_mac;
  logic [47:0] cmd_s_mac;
  logic [15:0] cmd_ethertype;
  logic [7:0]  cmd_payload;

  modport master (
    output cmd_valid, cmd_size, cmd_d_mac, cmd_s_mac, cmd_ethertype, cmd_payload,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_size, cmd_d_mac, cmd_s_mac, cmd_ethertype, cmd_payload,
    output cmd_ready
  );
endinterface

interface frame_builder_axis_if;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/frame_builder.sv
// frame_builder: turns one packet command (length, MACs, ethertype, fill
// byte) into one FCS-less Ethernet frame on a 64-bit AXI-Stream master.
// Header beat 0 is built straight from the command at acceptance, so only
// the fields needed by later beats are held in registers.

module frame_builder #(
  parameter int MIN_SIZE = 60,
  parameter int MAX_SIZE = 1514
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_builder_cmd_if.slave   cmd,
  frame_builder_axis_if.master m_axis,
  output logic [31:0]          tx_frames,
  output logic                 busy
);

  localparam logic [10:0] MIN_LEN    = 11'(MIN_SIZE);
  localparam logic [10:0] MAX_LEN    = 11'(MAX_SIZE);
  localparam logic [10:0] BEAT_BYTES = 11'd8;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD
  } state_t;

  state_t      state;

  // Registered stream outputs
  logic [63:0] tdata_r;
  logic [7:0]  tkeep_r;
  logic        tvalid_r;
  logic        tlast_r;

  // Command fields still needed after beat 0 has been formed
  logic [31:0] s_mac_hi_r;
  logic [15:0] etype_r;
  logic [7:0]  pay_r;

  // Bytes remaining in the frame, including the beat currently presented
  logic [10:0] rem_r;

  logic        hs;
  logic        frame_end;
  logic        cmd_ready_c;
  logic        accept;
  logic [10:0] new_len;
  logic [10:0] rem_nxt;
  logic [7:0]  new_keep;
  logic [7:0]  nxt_keep;
  logic [63:0] hdr0_beat;
  logic [63:0] hdr1_beat;
  logic [63:0] fill_beat;

  // Clamp the requested size into [MIN_LEN, MAX_LEN]; short frames get
  // padded with the fill byte, oversize ones are cut.
  function automatic logic [10:0] eff_len(input logic [10:0] size);
    logic [10:0] t;
    t = (size > MAX_LEN) ? MAX_LEN : size;
    return (t < MIN_LEN) ? MIN_LEN : t;
  endfunction

  // Byte enables for a beat given the bytes still to send from it onward.
  function automatic logic [7:0] beat_keep(input logic [10:0] rem);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) begin
      k[i] = (rem > 11'(i));
    end
    return k;
  endfunction

  // Zero every byte lane that is not enabled so trailing lanes are clean.
  function automatic logic [63:0] mask_beat(input logic [63:0] d, input logic [7:0] keep);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = keep[i] ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

  // Handshake decode and next-beat formation
  always_comb begin
    hs          = tvalid_r && m_axis.m_axis_tready;
    frame_end   = hs && tlast_r;
    cmd_ready_c = !rst && ((state == IDLE) || frame_end);
    accept      = cmd.cmd_valid && cmd_ready_c;

    new_len     = eff_len(cmd.cmd_size);
    new_keep    = beat_keep(new_len);
    rem_nxt     = rem_r - BEAT_BYTES;
    nxt_keep    = beat_keep(rem_nxt);

    hdr0_beat   = mask_beat({cmd.cmd_s_mac[15:0], cmd.cmd_d_mac}, new_keep);
    hdr1_beat   = mask_beat({pay_r, pay_r, etype_r, s_mac_hi_r}, nxt_keep);
    fill_beat   = mask_beat({8{pay_r}}, nxt_keep);
  end

  // Frame FSM: state, registered stream outputs, latched command, frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= '0;
      tkeep_r   <= '0;
      rem_r     <= '0;
      tx_frames <= '0;
    end else begin
      if (frame_end) begin
        tx_frames <= tx_frames + 32'd1;
      end

      if (accept) begin
        // New frame: present beat 0 immediately, keep what later beats need
        s_mac_hi_r <= cmd.cmd_s_mac[47:16];
        etype_r    <= cmd.cmd_ethertype;
        pay_r      <= cmd.cmd_payload;
        rem_r      <= new_len;
        tdata_r    <= hdr0_beat;
        tkeep_r    <= new_keep;
        tlast_r    <= (new_len <= BEAT_BYTES);
        tvalid_r   <= 1'b1;
        state      <= HDR0;
      end else if (frame_end) begin
        state    <= IDLE;
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
        tdata_r  <= '0;
        tkeep_r  <= '0;
      end else if (hs) begin
        rem_r   <= rem_nxt;
        tkeep_r <= nxt_keep;
        tlast_r <= (rem_nxt <= BEAT_BYTES);
        case (state)
          HDR0: begin
            tdata_r <= hdr1_beat;
            state   <= HDR1;
          end
          default: begin
            tdata_r <= fill_beat;
            state   <= PAYLOAD;
          end
        endcase
      end
    end
  end

  assign cmd.cmd_ready        = cmd_ready_c;
  assign m_axis.m_axis_tdata  = tdata_r;
  assign m_axis.m_axis_tkeep  = tkeep_r;
  assign m_axis.m_axis_tvalid = tvalid_r;
  assign m_axis.m_axis_tlast  = tlast_r;
  assign busy                 = (state != IDLE);

endmodule

// File: tb/tb_frame_builder.sv
// Testbench for frame_builder: directed header/length cases, random frames
// under random backpressure, back-to-back commands and reset mid-frame.
// Expected beats come from a byte-stream model of the frame.

module tb_frame_builder;

  localparam int MIN_SIZE = 60;
  localparam int MAX_SIZE = 1514;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tx_frames;
  logic        busy;

  frame_builder_cmd_if  cmd ();
  frame_builder_axis_if axs ();

  frame_builder #(
    .MIN_SIZE(MIN_SIZE),
    .MAX_SIZE(MAX_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .m_axis   (axs),
    .tx_frames(tx_frames),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic        bp_on    = 1'b0;
  int unsigned cyc      = 0;
  logic [31:0] exp_frames = 32'd0;

  logic [63:0] obs_data[$];
  logic [7:0]  obs_keep[$];
  logic        obs_last[$];
  int unsigned obs_cyc[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_keep[$];
  logic        exp_last[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: lay the frame out as a byte stream, then cut it into beats
  task automatic model_push(input logic [10:0] size, input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] e, input logic [7:0] p);
    int L;
    int nb;
    logic [63:0] dw;
    logic [7:0]  kw;
    logic [7:0]  b;
    L = int'(size);
    if (L > MAX_SIZE) L = MAX_SIZE;
    if (L < MIN_SIZE) L = MIN_SIZE;
    nb = (L + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      dw = '0;
      kw = '0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = bi * 8 + k;
        if (idx < L) begin
          if (idx < 6)       b = d[idx*8 +: 8];
          else if (idx < 12) b = s[(idx-6)*8 +: 8];
          else if (idx < 14) b = e[(idx-12)*8 +: 8];
          else               b = p;
          dw[k*8 +: 8] = b;
          kw[k] = 1'b1;
        end
      end
      exp_data.push_back(dw);
      exp_keep.push_back(kw);
      exp_last.push_back(bi == nb - 1);
    end
  endtask

  // Present one command, wait (bounded) for acceptance, then scramble the inputs
  task automatic send_cmd(input logic [10:0] size, input logic [47:0] d, input logic [47:0] s,
                          input logic [15:0] e, input logic [7:0] p);
    int n;
    model_push(size, d, s, e, p);
    cmd.cmd_size      = size;
    cmd.cmd_d_mac     = d;
    cmd.cmd_s_mac     = s;
    cmd.cmd_ethertype = e;
    cmd.cmd_payload   = p;
    cmd.cmd_valid     = 1'b1;
    n = 0;
    while (!cmd.cmd_ready && n < 5000) begin
      step();
      n++;
    end
    if (!cmd.cmd_ready) begin
      chk("accept_timeout", 64'(cmd.cmd_ready), 64'd1);
      cmd.cmd_valid = 1'b0;
      return;
    end
    step();
    chk("accept_latency_tvalid", 64'(axs.m_axis_tvalid), 64'd1);
    cmd.cmd_valid     = 1'b0;
    cmd.cmd_size      = 11'($urandom);
    cmd.cmd_d_mac     = {16'($urandom), 32'($urandom)};
    cmd.cmd_s_mac     = {16'($urandom), 32'($urandom)};
    cmd.cmd_ethertype = 16'($urandom);
    cmd.cmd_payload   = 8'($urandom);
  endtask

  task automatic wait_beats(input string tag, input int n);
    int t;
    t = 0;
    while (obs_data.size() < n && t < 10000) begin
      step();
      t++;
    end
    chk({tag, "_beats"}, 64'(obs_data.size()), 64'(n));
  endtask

  task automatic end_frame(input string tag, input logic [7:0] last_keep, input int nframes);
    int nb;
    nb = obs_data.size();
    if (nb > 0) begin
      chk({tag, "_last_keep"}, 64'(obs_keep[nb-1]), 64'(last_keep));
      chk({tag, "_last_tlast"}, 64'(obs_last[nb-1]), 64'd1);
    end
    exp_frames = exp_frames + 32'(nframes);
    chk({tag, "_tx_frames"}, 64'(tx_frames), 64'(exp_frames));
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i < obs_data.size()) begin
        chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        chk($sformatf("%s_keep%0d", tag, i), 64'(obs_keep[i]), 64'(exp_keep[i]));
        chk($sformatf("%s_last%0d", tag, i), 64'(obs_last[i]), 64'(exp_last[i]));
      end
    end
    obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_cyc.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
  endtask

  // Sink ready: constant high or random per cycle
  initial begin
    axs.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axs.m_axis_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: record accepted beats, check stability while stalled
  initial begin
    logic        stall;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    stall = 1'b0;
    pd = '0;
    pk = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_tvalid", 64'(axs.m_axis_tvalid), 64'd1);
          chk("hold_tdata", axs.m_axis_tdata, pd);
          chk("hold_tkeep", 64'(axs.m_axis_tkeep), 64'(pk));
          chk("hold_tlast", 64'(axs.m_axis_tlast), 64'(pl));
        end
        if (axs.m_axis_tvalid && axs.m_axis_tready) begin
          obs_data.push_back(axs.m_axis_tdata);
          obs_keep.push_back(axs.m_axis_tkeep);
          obs_last.push_back(axs.m_axis_tlast);
          obs_cyc.push_back(cyc);
        end
        stall = axs.m_axis_tvalid && !axs.m_axis_tready;
        pd = axs.m_axis_tdata;
        pk = axs.m_axis_tkeep;
        pl = axs.m_axis_tlast;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] sz;
    cmd.cmd_valid     = 1'b1;
    cmd.cmd_size      = 11'd60;
    cmd.cmd_d_mac     = '0;
    cmd.cmd_s_mac     = '0;
    cmd.cmd_ethertype = '0;
    cmd.cmd_payload   = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_tvalid", 64'(axs.m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(axs.m_axis_tlast), 64'd0);
    chk("rst_tdata", axs.m_axis_tdata, 64'd0);
    chk("rst_tkeep", 64'(axs.m_axis_tkeep), 64'd0);
    chk("rst_tx_frames", 64'(tx_frames), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd.cmd_ready), 64'd0);
    cmd.cmd_valid = 1'b0;
    rst = 1'b0;
    step();
    step();
    chk("idle_tvalid", 64'(axs.m_axis_tvalid), 64'd0);
    chk("idle_cmd_ready", 64'(cmd.cmd_ready), 64'd1);

    // Header layout, minimum length
    send_cmd(11'd60, 48'hBC9A78563412, 48'h111111111111, 16'h0008, 8'h1A);
    wait_beats("hdr", 8);
    if (obs_data.size() >= 2) begin
      chk("hdr_beat0", obs_data[0], 64'h1111BC9A78563412);
      chk("hdr_beat1", obs_data[1], 64'h1A1A000811111111);
    end
    end_frame("hdr", 8'h0F, 1);
    step();
    chk("post_idle_tvalid", 64'(axs.m_axis_tvalid), 64'd0);
    chk("post_idle_busy", 64'(busy), 64'd0);

    send_cmd(11'd64, 48'h0A0B0C0D0E0F, 48'h212223242526, 16'hDD86, 8'h5C);
    wait_beats("len64", 8);
    end_frame("len64", 8'hFF, 1);

    send_cmd(11'd20, 48'hFFEEDDCCBBAA, 48'h665544332211, 16'h0608, 8'hC3);
    wait_beats("pad20", 8);
    end_frame("pad20", 8'h0F, 1);

    send_cmd(11'd2047, 48'h123456789ABC, 48'hCAFEBABE0001, 16'h0081, 8'h77);
    wait_beats("clamp", 190);
    end_frame("clamp", 8'h03, 1);

    // Backpressure on a 100-byte frame
    bp_on = 1'b1;
    send_cmd(11'd100, 48'h010203040506, 48'h0708090A0B0C, 16'hB588, 8'h99);
    wait_beats("bp100", 13);
    end_frame("bp100", 8'h0F, 1);

    // Random frames under random backpressure
    for (int f = 0; f < 8; f++) begin
      sz = (f < 2) ? 11'($urandom_range(0, 80)) : 11'($urandom_range(0, 2047));
      send_cmd(sz, {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
               16'($urandom), 8'($urandom));
      wait_beats($sformatf("rnd%0d", f), exp_data.size());
      end_frame($sformatf("rnd%0d", f), exp_keep[exp_keep.size()-1], 1);
    end
    bp_on = 1'b0;
    step();
    step();

    // Back-to-back: second command waits in front of the builder
    send_cmd(11'd60, 48'h0000000000A1, 48'h0000000000B1, 16'h0008, 8'h11);
    send_cmd(11'd64, 48'h0000000000A2, 48'h0000000000B2, 16'h0008, 8'h22);
    wait_beats("b2b", 16);
    if (obs_cyc.size() >= 9) begin
      chk("b2b_gap", 64'(obs_cyc[8]), 64'(obs_cyc[7] + 1));
    end
    end_frame("b2b", 8'hFF, 2);

    // Reset while beat 3 of a frame is on the bus
    send_cmd(11'd60, 48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h0008, 8'h3C);
    wait_beats("rstmid", 3);
    rst = 1'b1;
    chk("rstmid_cmd_ready", 64'(cmd.cmd_ready), 64'd0);
    chk("rstmid_tx_before", 64'(tx_frames), 64'(exp_frames));
    chk("rstmid_tvalid_before", 64'(axs.m_axis_tvalid), 64'd1);
    step();
    chk("rstmid_tvalid", 64'(axs.m_axis_tvalid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_tx_after", 64'(tx_frames), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < obs_last.size(); i++) begin
      chk($sformatf("rstmid_no_tlast%0d", i), 64'(obs_last[i]), 64'd0);
    end
    exp_frames = 32'd0;
    obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_cyc.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    step();

    // Recovery after reset
    send_cmd(11'd61, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h0008, 8'hE1);
    wait_beats("recover", 8);
    end_frame("recover", 8'h1F, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
